// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
package multdiv_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned ITERS  = 32;
  localparam int unsigned CNT_W  = 6;
  localparam logic [WORD_W-1:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  typedef enum logic {
    OpMult = 1'b0,
    OpDiv  = 1'b1
  } op_e;

  // Unsigned magnitude of a two's complement word; INT_MIN maps to 2^31.
  function automatic logic [WORD_W-1:0] magnitude(input logic [WORD_W-1:0] v);
    return v[WORD_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/multdiv_if.sv
// Operand/control/result bundle between the execute stage and the mult/div unit.
interface multdiv_if;
  import multdiv_pkg::*;

  logic [WORD_W-1:0] data_operandA;
  logic [WORD_W-1:0] data_operandB;
  logic              ctrl_MULT;
  logic              ctrl_DIV;
  logic [WORD_W-1:0] data_result;
  logic              data_exception;
  logic              data_resultRDY;
  logic              busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );

endinterface

// File: rtl/multdiv_step.sv
// One iteration of the datapath: shift-add for multiply, restoring shift-subtract for divide.
// acc holds {hi, lo}: for multiply hi is the partial product and lo the remaining multiplier;
// for divide hi is the partial remainder and lo the dividend shifting into the quotient.
module multdiv_step
  import multdiv_pkg::*;
(
  input  op_e                 op_i,
  input  logic [2*WORD_W-1:0] acc_i,
  input  logic [WORD_W-1:0]   b_i,
  output logic [2*WORD_W-1:0] acc_o
);

  logic [WORD_W:0]   sum;
  logic [WORD_W-1:0] rem_shift;
  logic [WORD_W:0]   diff;

  // Single-iteration next value of the accumulator.
  always_comb begin
    // 33-bit add keeps the carry that shifts into the product's top bit.
    sum = {1'b0, acc_i[2*WORD_W-1:WORD_W]} + (acc_i[0] ? {1'b0, b_i} : '0);
    // The remainder stays below the divisor (<= 2^31), so its top bit is always zero.
    rem_shift = {acc_i[2*WORD_W-2:WORD_W], acc_i[WORD_W-1]};
    diff      = {1'b0, rem_shift} - {1'b0, b_i};
    if (op_i == OpMult) begin
      acc_o = {sum, acc_i[WORD_W-1:1]};
    end else if (diff[WORD_W]) begin
      acc_o = {rem_shift, acc_i[WORD_W-2:0], 1'b0};
    end else begin
      acc_o = {diff[WORD_W-1:0], acc_i[WORD_W-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32-bit multiply/divide unit: fixed 32-iteration latency, sign fix-up at DONE.
module multdiv_unit
  import multdiv_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  multdiv_if.slave        bus_io
);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  op_e                 op_q, op_d;
  logic                neg_q, neg_d;
  logic                bzero_q, bzero_d;
  logic [2*WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0]   b_q, b_d;
  logic [WORD_W-1:0]   res_q, res_d;
  logic                exc_q, exc_d;

  logic [2*WORD_W-1:0] acc_step;
  logic [2*WORD_W-1:0] prod_signed;
  logic [WORD_W-1:0]   quot_signed;
  logic [WORD_W-1:0]   fin_res;
  logic                fin_exc;
  logic                launch;

  multdiv_step u_step (
    .op_i  (op_q),
    .acc_i (acc_q),
    .b_i   (b_q),
    .acc_o (acc_step)
  );

  // Sign fix-up and exception detection on the final iteration's output.
  always_comb begin
    prod_signed = neg_q ? (~acc_step + 1'b1) : acc_step;
    quot_signed = neg_q ? (~acc_step[WORD_W-1:0] + 1'b1) : acc_step[WORD_W-1:0];
    if (op_q == OpMult) begin
      fin_res = prod_signed[WORD_W-1:0];
      fin_exc = prod_signed[2*WORD_W-1:WORD_W] != {WORD_W{prod_signed[WORD_W-1]}};
    end else if (bzero_q) begin
      fin_res = '0;
      fin_exc = 1'b1;
    end else begin
      fin_res = quot_signed;
      // A positive quotient with bit 31 set is only reachable as INT_MIN / -1.
      fin_exc = !neg_q && acc_step[WORD_W-1];
    end
  end

  // Next-state logic; a launch in any state restarts from count 0 with fresh operands.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    neg_d   = neg_q;
    bzero_d = bzero_q;
    acc_d   = acc_q;
    b_d     = b_q;
    res_d   = res_q;
    exc_d   = exc_q;
    launch  = bus_io.ctrl_MULT | bus_io.ctrl_DIV;

    unique case (state_q)
      StIdle: ;
      StRun: begin
        acc_d = acc_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(ITERS - 1)) begin
          state_d = StDone;
          res_d   = fin_res;
          exc_d   = fin_exc;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (launch) begin
      state_d = StRun;
      cnt_d   = '0;
      op_d    = bus_io.ctrl_MULT ? OpMult : OpDiv;
      neg_d   = bus_io.data_operandA[WORD_W-1] ^ bus_io.data_operandB[WORD_W-1];
      bzero_d = bus_io.data_operandB == '0;
      b_d     = magnitude(bus_io.data_operandB);
      acc_d   = {{WORD_W{1'b0}}, magnitude(bus_io.data_operandA)};
      // A discarded op never reaches DONE, so it must not touch the held result.
      res_d   = res_q;
      exc_d   = exc_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= OpMult;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
      acc_q   <= '0;
      b_q     <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      neg_q   <= neg_d;
      bzero_q <= bzero_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
    end
  end

  assign bus_io.data_result    = res_q;
  assign bus_io.data_exception = exc_q;
  assign bus_io.data_resultRDY = state_q == StDone;
  assign bus_io.busy           = state_q != StIdle;

endmodule
